// File: rtl/img_pattern_gen.sv
// Video timing and test-pattern source: vs/hs/de framing for a parametrised raster
// plus one of four pixel patterns, latched per frame. All outputs are registered.
module img_pattern_gen #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ACTIVE_IW = 1280,
  parameter int unsigned ACTIVE_IH = 720,
  parameter int unsigned TOTAL_IW  = 1650,
  parameter int unsigned TOTAL_IH  = 750,
  parameter int unsigned H_START   = 110,
  parameter int unsigned V_START   = 10,
  parameter int unsigned HS_LEN    = 40,
  parameter int unsigned VS_LEN    = 2,
  parameter int unsigned START_DLY = 5000,
  parameter int unsigned CNT_W     = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  output logic              pre_vs,
  output logic              pre_hs,
  output logic              pre_de,
  output logic [DATA_W-1:0] pre_data,
  output logic [CNT_W-1:0]  pre_x,
  output logic [CNT_W-1:0]  pre_y,
  output logic              frame_start,
  output logic [15:0]       frame_cnt
);

  localparam int unsigned DlyW = $clog2(START_DLY + 1);

  localparam logic [DlyW-1:0]  DlyLast = DlyW'(START_DLY - 1);
  localparam logic [CNT_W-1:0] HLast   = CNT_W'(TOTAL_IW - 1);
  localparam logic [CNT_W-1:0] VLast   = CNT_W'(TOTAL_IH - 1);
  localparam logic [CNT_W-1:0] HsEnd   = CNT_W'(HS_LEN);
  localparam logic [CNT_W-1:0] VsEnd   = CNT_W'(VS_LEN);
  localparam logic [CNT_W-1:0] HStart  = CNT_W'(H_START);
  localparam logic [CNT_W-1:0] HEnd    = CNT_W'(H_START + ACTIVE_IW);
  localparam logic [CNT_W-1:0] VStart  = CNT_W'(V_START);
  localparam logic [CNT_W-1:0] VEnd    = CNT_W'(V_START + ACTIVE_IH);
  localparam logic [CNT_W-1:0] SubLast = CNT_W'(ACTIVE_IW / 8 - 1);

  typedef enum logic [1:0] {StDelay, StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [DlyW-1:0]   dly_q, dly_d;
  logic [CNT_W-1:0]  h_q, h_d, v_q, v_d;
  logic [1:0]        mode_q, mode_d;
  logic [15:0]       fcnt_q, fcnt_d;
  logic [DATA_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  sub_q, sub_d;
  logic [2:0]        bar_q, bar_d;

  logic              running, frame_end;
  logic              vs_nxt, hs_nxt, de_nxt, fs_nxt;
  logic [CNT_W-1:0]  x_nxt, y_nxt;
  logic [DATA_W-1:0] data_nxt;

  assign running   = (state_q == StRun);
  assign frame_end = running && (h_q == HLast) && (v_q == VLast);
  assign frame_cnt = fcnt_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StDelay;
    else        state_q <= state_d;
  end

  // Next-state logic; a frame is never cut short by en dropping
  always_comb begin
    state_d = state_q;
    case (state_q)
      StDelay: if (dly_q == DlyLast) state_d = StIdle;
      StIdle:  if (en) state_d = StRun;
      StRun:   if (frame_end && !en) state_d = StIdle;
      default: state_d = StDelay;
    endcase
  end

  // Raster counters, mode latch and frame count
  always_comb begin
    dly_d  = dly_q;
    h_d    = h_q;
    v_d    = v_q;
    mode_d = mode_q;
    fcnt_d = fcnt_q;
    case (state_q)
      StDelay: if (dly_q != DlyLast) dly_d = dly_q + 1'b1;
      StIdle: begin
        h_d = '0;
        v_d = '0;
        if (en) mode_d = mode;
      end
      StRun: begin
        if (h_q == HLast) begin
          h_d = '0;
          v_d = (v_q == VLast) ? '0 : v_q + 1'b1;
        end else begin
          h_d = h_q + 1'b1;
        end
        if (frame_end) begin
          fcnt_d = fcnt_q + 1'b1;
          if (en) mode_d = mode;
        end
      end
      default: ;
    endcase
  end

  // Output decode from the current counter state; registered below
  always_comb begin
    de_nxt = running && (h_q >= HStart) && (h_q < HEnd) && (v_q >= VStart) && (v_q < VEnd);
    vs_nxt = running && (v_q >= VsEnd);
    hs_nxt = running && (h_q >= HsEnd);
    fs_nxt = running && (h_q == '0) && (v_q == '0);
    x_nxt  = de_nxt ? h_q - HStart : '0;
    y_nxt  = de_nxt ? v_q - VStart : '0;

    // Index and bar counters advance per active pixel instead of multiplying/dividing
    idx_d = idx_q;
    sub_d = '0;
    bar_d = '0;
    if (!running || frame_end) begin
      idx_d = '0;
    end else if (de_nxt) begin
      idx_d = idx_q + 1'b1;
    end
    if (de_nxt) begin
      if (sub_q == SubLast) begin
        sub_d = '0;
        bar_d = bar_q + 1'b1;
      end else begin
        sub_d = sub_q + 1'b1;
        bar_d = bar_q;
      end
    end

    data_nxt = '0;
    if (de_nxt) begin
      unique case (mode_q)
        2'd0: data_nxt = idx_q;
        2'd1: data_nxt = DATA_W'(x_nxt);
        2'd2: data_nxt[DATA_W-1 -: 3] = bar_q;
        2'd3: data_nxt = {DATA_W{x_nxt[5] ^ y_nxt[5] ^ fcnt_q[0]}};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_q       <= '0;
      h_q         <= '0;
      v_q         <= '0;
      mode_q      <= '0;
      fcnt_q      <= '0;
      idx_q       <= '0;
      sub_q       <= '0;
      bar_q       <= '0;
      pre_vs      <= 1'b0;
      pre_hs      <= 1'b0;
      pre_de      <= 1'b0;
      pre_data    <= '0;
      pre_x       <= '0;
      pre_y       <= '0;
      frame_start <= 1'b0;
    end else begin
      dly_q       <= dly_d;
      h_q         <= h_d;
      v_q         <= v_d;
      mode_q      <= mode_d;
      fcnt_q      <= fcnt_d;
      idx_q       <= idx_d;
      sub_q       <= sub_d;
      bar_q       <= bar_d;
      pre_vs      <= vs_nxt;
      pre_hs      <= hs_nxt;
      pre_de      <= de_nxt;
      pre_data    <= data_nxt;
      pre_x       <= x_nxt;
      pre_y       <= y_nxt;
      frame_start <= fs_nxt;
    end
  end

endmodule
